round_key_sequencer: RTL and testbench

//  Downstream consumer of key_expansion. Captures the full packed key schedule on its o_valid

---
 rtl/round_key_sequencer.sv | 152 +++++++++++++++
 tb/tb_round_key_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_key_sequencer.sv
// rtl/round_key_sequencer.sv - captures an AES key schedule and streams round keys in either order
//
// Purpose: holds the packed schedule produced by key_expansion and hands one round key
// per rk_valid/rk_ready handshake to the iterative cipher core. The order is forward
// (0..Nr) for encryption and reverse (Nr..0) for decryption.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-low reset
//   sched_valid          one-cycle capture strobe for key_schedule
//   key_schedule         round k at [k*KEY_LENGTH +: KEY_LENGTH], round 0 in LSBs
//   start, decrypt       stream request and its direction (sampled together)
//   rk_ready             consumer accepts the current beat
//   rk_valid, round_key  current beat and its key (key reads 0 when not valid)
//   round_idx, last      round number of the beat, final-beat flag
//   loaded, busy         schedule held / stream in progress
//   sched_drop           pulse: a schedule arrived mid-stream and was discarded
//   zeroize              (ROUND_KEY_ZEROIZE_EN only) wipes the schedule and aborts
//
// Optional feature macro: ROUND_KEY_ZEROIZE_EN

module round_key_sequencer #(
  parameter int KEY_LENGTH  = 128,
  parameter int WORD_LENGTH = 32,
  parameter int Nb          = 4,
  parameter int Nr          = 10,
  parameter int SCHED_W     = Nb * (Nr + 1) * WORD_LENGTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sched_valid,
  input  logic [SCHED_W-1:0]    key_schedule,
  input  logic                  start,
  input  logic                  decrypt,
  input  logic                  rk_ready,
`ifdef ROUND_KEY_ZEROIZE_EN
  input  logic                  zeroize,
`endif
  output logic                  rk_valid,
  output logic [KEY_LENGTH-1:0] round_key,
  output logic [3:0]            round_idx,
  output logic                  last,
  output logic                  loaded,
  output logic                  busy,
  output logic                  sched_drop
);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    LOADED = 2'd1,
    STREAM = 2'd2
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(Nr);

  state_t              state_q, state_d;
  logic [SCHED_W-1:0]  sched_q;
  logic                dir_q;
  logic [3:0]          idx_q;
  logic                drop_q;
  logic                capture, launch, advance, last_beat, zero_req;
  logic [KEY_LENGTH-1:0] rk_words [0:Nr];

`ifdef ROUND_KEY_ZEROIZE_EN
  assign zero_req = zeroize;
`else
  assign zero_req = 1'b0;
`endif

  // Round-key view of the held schedule; outputs are a mux on registered state only.
  for (genvar k = 0; k <= Nr; k++) begin : g_words
    assign rk_words[k] = sched_q[k*KEY_LENGTH +: KEY_LENGTH];
  end

  // Final beat depends on direction: idx Nr going forward, idx 0 going backward.
  assign last_beat = dir_q ? (idx_q == 4'd0) : (idx_q == LAST_IDX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    launch  = 1'b0;
    advance = 1'b0;
    case (state_q)
      EMPTY: begin
        if (sched_valid) begin
          capture = 1'b1;
          state_d = LOADED;
        end
      end
      LOADED: begin
        capture = sched_valid;
        if (start) begin
          launch  = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (rk_ready) begin
          if (last_beat) state_d = LOADED;
          else           advance = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Zeroize outranks every other request, including an in-flight stream.
    if (zero_req) begin
      state_d = EMPTY;
      capture = 1'b0;
      launch  = 1'b0;
      advance = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sched_q <= '0;
      dir_q   <= 1'b0;
      idx_q   <= 4'd0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= sched_valid && (state_q == STREAM) && !zero_req;
      if (zero_req) begin
        sched_q <= '0;
        idx_q   <= 4'd0;
      end else begin
        if (capture) sched_q <= key_schedule;
        if (launch) begin
          dir_q <= decrypt;
          idx_q <= decrypt ? LAST_IDX : 4'd0;
        end else if (advance) begin
          idx_q <= dir_q ? idx_q - 4'd1 : idx_q + 4'd1;
        end
      end
    end
  end

  assign rk_valid   = (state_q == STREAM);
  assign busy       = rk_valid;
  assign loaded     = (state_q != EMPTY);
  assign round_idx  = idx_q;
  assign last       = rk_valid & last_beat;
  assign round_key  = rk_valid ? rk_words[idx_q] : '0;
  assign sched_drop = drop_q;

endmodule

// File: tb/tb_round_key_sequencer.sv
// tb/tb_round_key_sequencer.sv - self-checking bench for round_key_sequencer
module tb_round_key_sequencer;

  localparam int NR = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          sched_valid = 1'b0;
  logic [1407:0] key_schedule = '0;
  logic          start = 1'b0;
  logic          decrypt = 1'b0;
  logic          rk_ready = 1'b0;
  logic          zeroize = 1'b0;
  logic          rk_valid;
  logic [127:0]  round_key;
  logic [3:0]    round_idx;
  logic          last;
  logic          loaded;
  logic          busy;
  logic          sched_drop;

  int vectors = 0;
  int errors  = 0;

  logic [127:0] model_keys [0:NR];
  logic [127:0] fips_keys  [0:NR];

  round_key_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .sched_valid  (sched_valid),
    .key_schedule (key_schedule),
    .start        (start),
    .decrypt      (decrypt),
    .rk_ready     (rk_ready),
`ifdef ROUND_KEY_ZEROIZE_EN
    .zeroize      (zeroize),
`endif
    .rk_valid     (rk_valid),
    .round_key    (round_key),
    .round_idx    (round_idx),
    .last         (last),
    .loaded       (loaded),
    .busy         (busy),
    .sched_drop   (sched_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packs an array of round keys into the schedule bus (round 0 in the LSBs).
  function automatic logic [1407:0] pack(input logic [127:0] keys [0:NR]);
    logic [1407:0] s = '0;
    for (int k = 0; k <= NR; k++) s[k*128 +: 128] = keys[k];
    return s;
  endfunction

  task automatic random_keys(output logic [127:0] keys [0:NR]);
    for (int k = 0; k <= NR; k++) keys[k] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Drives a one-cycle sched_valid, the model adopts the same keys.
  task automatic load_sched(input logic [127:0] keys [0:NR]);
    key_schedule = pack(keys);
    model_keys   = keys;
    sched_valid  = 1'b1;
    tick();
    sched_valid  = 1'b0;
  endtask

  task automatic check_idle(input string tag, input logic exp_loaded);
    chk({tag, "_valid"}, 128'(rk_valid), 128'd0);
    chk({tag, "_key"},   round_key,      128'd0);
    chk({tag, "_busy"},  128'(busy),     128'd0);
    chk({tag, "_last"},  128'(last),     128'd0);
    chk({tag, "_loaded"}, 128'(loaded),  128'(exp_loaded));
  endtask

  // Runs one stream and compares each beat with the expected order derived from
  // direction: beat b carries round b forward, or round NR-b in reverse.
  // stall_at: hold rk_ready low for 3 cycles at that idx. collide_beat: pulse
  // sched_valid with a fresh schedule during that beat. abort_at/abort_kind:
  // at that idx apply async reset (1) or zeroize (2) and stop.
  task automatic run_stream(input string tag, input logic dir, input int stall_at,
                            input int collide_beat, input int abort_at, input int abort_kind);
    int b = 0;
    int cyc = 0;
    int stalls = 0;
    int exp_idx;
    logic drop_exp = 1'b0;
    logic collided = 1'b0;
    logic ready;
    logic [127:0] junk [0:NR];
    decrypt = dir;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    decrypt = $urandom_range(0, 1);
    while (b <= NR && cyc < 200) begin
      cyc++;
      exp_idx = dir ? NR - b : b;
      if (exp_idx == abort_at && abort_kind == 1) begin
        reset = 1'b0;
        #1;
        check_idle({tag, "_rst_abort"}, 1'b0);
        chk({tag, "_rst_idx"}, 128'(round_idx), 128'd0);
        chk({tag, "_rst_drop"}, 128'(sched_drop), 128'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check_idle({tag, "_post_rst"}, 1'b0);
        return;
      end
      if (exp_idx == abort_at && abort_kind == 2) begin
        zeroize  = 1'b1;
        rk_ready = 1'b0;
        tick();
        zeroize  = 1'b0;
        check_idle({tag, "_zeroize"}, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_idle({tag, "_zero_start"}, 1'b0);
        return;
      end
      if (stall_at >= 0 && exp_idx == stall_at && stalls < 3) begin
        ready = 1'b0;
        stalls++;
      end else if (stall_at >= 0 || collide_beat >= 0) begin
        ready = 1'b1;
      end else begin
        ready = ($urandom_range(0, 3) != 0);
      end
      rk_ready = ready;
      if (b == collide_beat && !collided) begin
        random_keys(junk);
        key_schedule = pack(junk);
        sched_valid  = 1'b1;
        collided     = 1'b1;
      end
      chk({tag, "_valid"}, 128'(rk_valid),  128'd1);
      chk({tag, "_busy"},  128'(busy),      128'd1);
      chk({tag, "_idx"},   128'(round_idx), 128'(exp_idx));
      chk({tag, "_key"},   round_key,       model_keys[exp_idx]);
      chk({tag, "_last"},  128'(last),      128'(b == NR));
      chk({tag, "_drop"},  128'(sched_drop), 128'(drop_exp));
      drop_exp = sched_valid;
      tick();
      sched_valid = 1'b0;
      if (ready) b++;
    end
    chk({tag, "_budget"}, 128'(cyc < 200), 128'd1);
    rk_ready = 1'b0;
    check_idle({tag, "_end"}, 1'b1);
    chk({tag, "_end_drop"}, 128'(sched_drop), 128'(drop_exp));
  endtask

  initial begin
    logic [127:0] keys [0:NR];
    fips_keys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_keys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_keys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_keys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_keys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_keys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_keys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_keys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_keys[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_keys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    // Reset held with random inputs: every output stays 0.
    for (int i = 0; i < 4; i++) begin
      sched_valid  = $urandom_range(0, 1);
      start        = $urandom_range(0, 1);
      decrypt      = $urandom_range(0, 1);
      rk_ready     = $urandom_range(0, 1);
      key_schedule = {44{$urandom}};
      tick();
      check_idle("reset", 1'b0);
      chk("reset_idx",  128'(round_idx),  128'd0);
      chk("reset_drop", 128'(sched_drop), 128'd0);
    end
    sched_valid = 1'b0;
    start       = 1'b0;
    rk_ready    = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    tick();
    check_idle("released", 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_idle("empty_start", 1'b0);
    tick();
    check_idle("empty_start2", 1'b0);

    // FIPS-197 schedule, forward then reverse with rk_ready held high.
    load_sched(fips_keys);
    check_idle("loaded", 1'b1);
    chk("fips_beat1", model_keys[1], 128'ha0fafe1788542cb123a339392a6c7605);
    run_stream("fwd", 1'b0, 0 - 1, 0 - 1, 0 - 1, 0);
    run_stream("rev", 1'b1, 0 - 1, 0 - 1, 0 - 1, 0);

    // Backpressure at idx 4 for 3 cycles.
    run_stream("stall", 1'b0, 4, 0 - 1, 0 - 1, 0);

    // Schedule arriving mid-stream is dropped; stream keeps the old keys.
    run_stream("collide", 1'b0, 0 - 1, 3, 0 - 1, 0);
    run_stream("collide_rev", 1'b1, 0 - 1, 5, 0 - 1, 0);

    // start and sched_valid together in LOADED: stream uses the new schedule.
    random_keys(keys);
    key_schedule = pack(keys);
    model_keys   = keys;
    sched_valid  = 1'b1;
    decrypt      = 1'b0;
    start        = 1'b1;
    tick();
    sched_valid  = 1'b0;
    start        = 1'b0;
    chk("same_cycle_key0", round_key, keys[0]);
    rk_ready = 1'b1;
    while (rk_valid) tick();
    rk_ready = 1'b0;
    check_idle("same_cycle_end", 1'b1);

    // Random schedules with random backpressure in both directions.
    for (int t = 0; t < 4; t++) begin
      random_keys(keys);
      load_sched(keys);
      run_stream("rand", t[0], 0 - 1, 0 - 1, 0 - 1, 0);
    end

    // Async reset at idx 6 loses the schedule.
    load_sched(fips_keys);
    run_stream("abort_rst", 1'b0, 0 - 1, 0 - 1, 6, 1);

`ifdef ROUND_KEY_ZEROIZE_EN
    load_sched(fips_keys);
    run_stream("abort_zero", 1'b0, 0 - 1, 0 - 1, 3, 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
